one_by_root2_seq_scaler: RTL and testbench
==========================================

// Module: one_by_root2_seq_scaler
// PURPOSE
//  Sequenced, area-reduced 1/sqrt(2) scaler for unsigned operands.
//  - One shared WIDTH-bit adder evaluates the five shift-add terms, one term per clock:
//    out = (x>>1)+(x>>3)+(x>>4)+(x>>6)+(x>>8)  (~0.70703125*x)
//  - Result is bit-exact with the combinational 1/sqrt(2) constant multiplier.
//  - Sits between an upstream producer and a downstream consumer, connected by valid/ready handshakes.
// PARAMETERS
//  WIDTH  16  operand/result width, unsigned; must be >= 9
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      upstream operand valid
//  in_ready   out  1      block can accept an operand
//  in_data    in   WIDTH  operand x
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  scaled result
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset values:
//  - rst high forces state=IDLE; op, acc, term index and out_data all 0.
//  - Outputs during reset: in_ready=1, out_valid=0, busy=0.
//  - Reset is effective immediately, independent of clk.
//  - Reset mid-operation discards the operand in flight; no result is produced.
//  FSM states: IDLE -> ACCUM -> DONE -> IDLE.
//  - IDLE:
//    - in_ready=1.
//    - On a clk edge with in_valid=1: op<=in_data, acc<=0, idx<=0, go to ACCUM.
//  - ACCUM:
//    - in_ready=0; busy=1.
//    - Each edge: acc <= acc + (op >> SH[idx]), with SH = {1,3,4,6,8}; idx increments.
//    - On the edge where idx=4, go to DONE.
//    - Exactly 5 ACCUM cycles.
//  - DONE:
//    - out_valid=1; out_data=acc.
//    - On an edge with out_ready=1: go to IDLE; out_valid drops next cycle.
//    - With out_ready=0: hold indefinitely; out_data stays stable.
//  Latency and throughput:
//  - Accept edge = edge 0. out_valid is high after edge 5.
//  - Best-case throughput: one result per 7 cycles (IDLE, 5x ACCUM, DONE).
//  - No operand is accepted while busy. in_valid is ignored outside IDLE.
//  - in_data is sampled only on the accept edge; later changes to it have no effect.
//  Arithmetic:
//  - Logical right shifts, zero-filled.
//  - Adder is WIDTH bits, carry-in 0. The sum is always < x, so it cannot overflow; no carry-out port.
//  - Truncation happens per term before summing, identical to the chained RSH1 datapath.
//  Simultaneous events:
//  - out_ready=1 in DONE together with in_valid=1: no bypass. The block returns to IDLE first and the new operand is accepted on the following edge.
//  - out_ready asserted outside DONE has no effect.
// TESTING
//  T1  rst pulse mid-ACCUM (after 2 terms) -> in_ready=1, out_valid=0, out_data=0 immediately; no result emitted.
//  T2  in_data=16'h8000, out_ready=1 -> out_valid after 5 ACCUM cycles, out_data=16'h5A80 (23168).
//  T3  in_data=16'hFFFF -> out_data=16'hB4FB (46331); no overflow.
//  T4  in_data=100, then in_data=0 -> 69, then 0; in_ready low for the whole busy interval.
//  T5  out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, new in_valid ignored; then out_ready=1 -> back to IDLE.
//  T6  Random 1000 operands with random valid/ready stalls -> every result equals the combinational reference model; no drops or duplicates.

Source files
------------

// File: rtl/one_by_root2_seq_scaler.sv
// Sequenced 1/sqrt(2) scaler: one shared adder accumulates the five shift-add
// terms (x>>1)+(x>>3)+(x>>4)+(x>>6)+(x>>8), one term per clock.
module one_by_root2_seq_scaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] acc;
    logic [2:0]       idx;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] sum;

    // Each term is truncated before summing, matching the combinational
    // constant multiplier bit for bit.
    always_comb begin
        term = '0;
        case (idx)
            3'd0:    term = op >> 1;
            3'd1:    term = op >> 3;
            3'd2:    term = op >> 4;
            3'd3:    term = op >> 6;
            default: term = op >> 8;
        endcase
        sum = acc + term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            acc       <= '0;
            idx       <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= in_data;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= ACCUM;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= sum;
                    idx <= idx + 3'd1;
                    if (idx == 3'd4) begin
                        state     <= DONE;
                        out_data  <= sum;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // No bypass: a waiting operand is taken on the next edge from IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_one_by_root2_seq_scaler.sv
// Directed bench for one_by_root2_seq_scaler: reset, timing, stall and
// back-to-back handshakes with hand-computed results.
module tb_one_by_root2_seq_scaler;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    one_by_root2_seq_scaler #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_scale(input logic [15:0] x);
        return (x >> 1) + (x >> 3) + (x >> 4) + (x >> 6) + (x >> 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the block in IDLE; returns the same way.
    task automatic run_op(input logic [15:0] x, input logic [15:0] exp, input int stall);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~x;
        chk("accept_busy", busy, 1);
        chk("accept_in_ready", in_ready, 0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i < 5) begin
                chk("accum_out_valid", out_valid, 0);
                chk("accum_in_ready", in_ready, 0);
            end
        end
        chk("done_out_valid", out_valid, 1);
        chk("done_out_data", out_data, exp);
        chk("done_in_ready", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ret_out_valid", out_valid, 0);
        chk("ret_in_ready", in_ready, 1);
        chk("ret_busy", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // T2 / T3 / T4: directed vectors
        run_op(16'h8000, 16'h5A80, 0);
        run_op(16'hFFFF, 16'hB4FB, 1);
        run_op(16'd100, 16'd69, 0);
        run_op(16'd0, 16'd0, 0);

        // T1: reset after two accumulated terms discards the operand
        run_op(16'h8000, 16'h5A80, 0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("t1_in_ready", in_ready, 1);
        chk("t1_out_valid", out_valid, 0);
        chk("t1_out_data", out_data, 0);
        chk("t1_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("t1_no_result", out_valid, 0);
        end

        // T5: long stall in DONE with in_valid asserted, then no-bypass return
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(posedge clk); #1;
        in_data = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_data", out_data, 16'd3293);
            chk("t5_hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_data   = 16'd100;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_idle_in_ready", in_ready, 1);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_accept_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        chk("t5_next_valid", out_valid, 1);
        chk("t5_next_data", out_data, 16'd69);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_next_ret", in_ready, 1);

        // T6 (reduced): random operands with random output stalls
        for (int n = 0; n < 40; n++) begin
            logic [15:0] x;
            x = 16'($urandom);
            run_op(x, ref_scale(x), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
